tdm_demux_4ch: RTL and testbench
================================

Name: tdm_demux_4ch

Overview:
- Time-division demultiplexer: the receive-side counterpart of the 4:1 channel select mux.
- Accepts one serial word stream, in which 4 channel words are interleaved per frame, marked by a start-of-frame flag.
- Steers each word into its channel slot and presents a complete frame as one parallel bundle.
- The bundle is released with a valid/ready handshake to the downstream consumer.

Parameters:
- W, 8, width of one channel word.
- CH, 4, channels per frame; fixed at 4 (slot counter is 2 bits).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_sof carry a word this cycle.
- in_sof  input  1  word is slot 0 of a new frame; meaningful only with in_valid.
- in_data  input  W  channel word.
- out_valid  output  1  out_data holds a complete, unconsumed frame.
- out_ready  input  1  consumer accepts out_data when out_valid.
- out_data  output  CH*W  frame; channel k at bits [k*W +: W].
- frame_err  output  1  one-cycle pulse: sof received mid-frame (frame aborted).
- overrun  output  1  one-cycle pulse: completed frame dropped, output still held.

Behaviour:
- Reset (async assert, sync release): state=HUNT, slot=0, out_valid=0, out_data=0, frame_err=0, overrun=0, staging registers=0.
- Input is never back-pressured; every in_valid beat is consumed the cycle it appears.
- HUNT:
  - in_valid && !in_sof: discard the word.
  - in_valid && in_sof: write staging[0], slot<=1, go to COLLECT.
- COLLECT:
  - in_valid && !in_sof: write staging[slot], slot<=slot+1.
  - When slot==3 is written: frame is complete; slot wraps to 0; state returns to HUNT.
  - in_valid && in_sof with slot!=0: frame_err pulses next cycle; the partial frame is discarded; the word is taken as the new slot 0 (staging[0], slot<=1, stay in COLLECT).
  - Cycles without in_valid: hold state; no timeout.
- Frame completion (slot 3 write at edge N):
  - If the output is free, or is being consumed this cycle (out_valid && out_ready), then at edge N:
    - out_data <= {in_data, staging[2], staging[1], staging[0]};
    - out_valid <= 1.
  - Latency: last word to out_valid is 1 cycle.
  - Otherwise (out_valid && !out_ready): out_data and out_valid are unchanged; the new frame is dropped; overrun pulses for 1 cycle.
- Output handshake:
  - out_valid stays high and out_data stays stable until a cycle with out_ready=1.
  - In that cycle out_valid clears, unless a new frame completes in the same cycle (back-to-back reload, no bubble).
- Stale slots never leak: staging writes only affect out_data at completion, and out_data updates atomically.
- Reset asserted mid-frame or mid-handshake: all state clears immediately; the partial frame is lost.
- frame_err and overrun are registered pulses and never stretch. They can both pulse in different cycles of the same frame sequence.

Decomposition:
- Shared package tdm_pkg:
  - state enum {HUNT, COLLECT};
  - CH_LOG2=2;
  - slot-index typedef (2-bit).
- One sub-module, demux_1to4_en:
  - combinational 1-to-4 decoder from slot and write-enable to per-channel staging write enables;
  - the inverse of the 4:1 select mux.
  - It is instantiated once.
- Staging registers, FSM, output buffer and handshake stay in tdm_demux_4ch.

Test Plan:
- Nominal frame:
  - Stimulus: beats sof+0x11, 0x22, 0x33, 0x44 on consecutive cycles, out_ready=1.
  - Response: out_valid pulses 1 cycle after 0x44; out_data=0x44332211.
- Hunt discard:
  - Stimulus: beats 0xAA, 0xBB without sof, then a full frame 0x01..0x04.
  - Response: out_data=0x04030201; no frame_err.
- Mid-frame resync:
  - Stimulus: sof+0x10, 0x20, then sof+0x50, 0x60, 0x70, 0x80.
  - Response: frame_err pulses once, after the second sof; out_data=0x80706050.
- Backpressure/overrun:
  - Stimulus: out_ready=0, two complete frames (0x..A1 series, then 0x..B1 series).
  - Response: out_data keeps the first frame; overrun pulses once; out_valid stays 1 until out_ready=1.
- Back-to-back with gaps:
  - Stimulus: in_valid idle cycles inserted between slots; out_ready asserted on the same cycle the next frame completes.
  - Response: out_valid stays high continuously; out_data switches to the new frame; no overrun.
- Async reset:
  - Stimulus: rst_n low after slot 2 of a frame, then release, then a full frame 0x05..0x08.
  - Response: outputs 0 during reset; the first out_data after release=0x08070605.

Source files
------------

// File: rtl/tdm_demux_4ch_pkg.sv
// Shared types for the 4-channel TDM demultiplexer: FSM states and slot index.
package tdm_pkg;
    localparam int unsigned CH_LOG2 = 2;
    localparam int unsigned NUM_CH  = 1 << CH_LOG2;

    typedef enum logic {
        HUNT,
        COLLECT
    } state_e;

    typedef logic [CH_LOG2-1:0] slot_t;
endpackage

// File: rtl/tdm_demux_4ch_if.sv
// Serial word input and parallel frame output bundle of the TDM demultiplexer.
interface tdm_demux_4ch_if #(
    parameter int unsigned W  = 8,
    parameter int unsigned CH = 4
);
    logic            in_valid;
    logic            in_sof;
    logic [W-1:0]    in_data;
    logic            out_valid;
    logic            out_ready;
    logic [CH*W-1:0] out_data;
    logic            frame_err;
    logic            overrun;

    modport master (
        output in_valid, in_sof, in_data, out_ready,
        input  out_valid, out_data, frame_err, overrun
    );

    modport slave (
        input  in_valid, in_sof, in_data, out_ready,
        output out_valid, out_data, frame_err, overrun
    );
endinterface

// File: rtl/tdm_demux_4ch_demux_1to4_en.sv
// 1-to-4 write-enable decoder: routes one enable to the staging slot selected by slot_i.
module demux_1to4_en
    import tdm_pkg::*;
(
    input  slot_t             slot_i,
    input  logic              en_i,
    output logic [NUM_CH-1:0] we_o
);
    always_comb begin
        we_o         = '0;
        we_o[slot_i] = en_i;
    end
endmodule

// File: rtl/tdm_demux_4ch.sv
// TDM demultiplexer: collects 4 interleaved channel words per frame and releases each
// complete frame as one parallel bundle over a valid/ready handshake.
module tdm_demux_4ch
    import tdm_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned CH = 4
) (
    input logic           clk,
    input logic           rst_n,
    tdm_demux_4ch_if.slave bus
);
    state_e            state_q, state_d;
    slot_t             slot_q, slot_d;
    logic [W-1:0]      stg_q [NUM_CH];
    logic [CH*W-1:0]   out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;

    logic              wr_en;
    slot_t             wr_slot;
    logic              frame_done;
    logic [NUM_CH-1:0] stg_we;

    // A sof always lands in slot 0, whether it opens a frame or resyncs one.
    assign wr_slot = bus.in_sof ? '0 : slot_q;

    demux_1to4_en u_demux (
        .slot_i (wr_slot),
        .en_i   (wr_en),
        .we_o   (stg_we)
    );

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        wr_en       = 1'b0;
        frame_done  = 1'b0;
        frame_err_d = 1'b0;
        if (bus.in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.in_sof) begin
                        wr_en   = 1'b1;
                        slot_d  = slot_t'(1);
                        state_d = COLLECT;
                    end
                end
                COLLECT: begin
                    wr_en = 1'b1;
                    if (bus.in_sof) begin
                        frame_err_d = (slot_q != '0);
                        slot_d      = slot_t'(1);
                    end else if (slot_q == slot_t'(NUM_CH - 1)) begin
                        frame_done = 1'b1;
                        slot_d     = '0;
                        state_d    = HUNT;
                    end else begin
                        slot_d = slot_q + slot_t'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // The last word bypasses staging so the bundle is available one cycle after it.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = 1'b0;
        if (frame_done) begin
            if (!out_valid_q || bus.out_ready) begin
                out_data_d  = {bus.in_data, stg_q[2], stg_q[1], stg_q[0]};
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            slot_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NUM_CH; k++) stg_q[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (stg_we[k]) stg_q[k] <= bus.in_data;
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Directed self-checking bench for tdm_demux_4ch.
module tb_tdm_demux_4ch;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   ferr_cnt;
    int   ovr_cnt;

    tdm_demux_4ch_if #(.W(8), .CH(4)) bus ();

    tdm_demux_4ch #(.W(8), .CH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each pulse spans one full cycle, so every pulse is seen at exactly one negedge.
    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) ferr_cnt++;
        if (bus.overrun === 1'b1) ovr_cnt++;
    end

    // Present one input beat at negedge; return 1 time unit after the capturing edge.
    task automatic beat(input logic v, input logic sof, input logic [7:0] d);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_sof   = sof;
        bus.in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        beat(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #12;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_out got valid=%b data=%h exp valid=0 data=00000000", bus.out_valid, bus.out_data);
        end
        checks++;
        if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got ferr=%b ovr=%b exp 0 0", bus.frame_err, bus.overrun);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ferr_cnt = 0;
        ovr_cnt  = 0;
    endtask

    task automatic test_nominal();
        bus.out_ready = 1'b1;
        beat(1'b1, 1'b1, 8'h11);
        beat(1'b1, 1'b0, 8'h22);
        beat(1'b1, 1'b0, 8'h33);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL nominal_early_valid got=%b exp=0", bus.out_valid);
        end
        beat(1'b1, 1'b0, 8'h44);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h44332211) begin
            failures++;
            $display("FAIL nominal_frame got valid=%b data=%h exp valid=1 data=44332211", bus.out_valid, bus.out_data);
        end
        idle();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL nominal_consume got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_hunt_discard();
        ferr_cnt = 0;
        bus.out_ready = 1'b1;
        beat(1'b1, 1'b0, 8'hAA);
        beat(1'b1, 1'b0, 8'hBB);
        beat(1'b1, 1'b1, 8'h01);
        beat(1'b1, 1'b0, 8'h02);
        beat(1'b1, 1'b0, 8'h03);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL hunt_early_valid got=%b exp=0", bus.out_valid);
        end
        beat(1'b1, 1'b0, 8'h04);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h04030201) begin
            failures++;
            $display("FAIL hunt_frame got valid=%b data=%h exp valid=1 data=04030201", bus.out_valid, bus.out_data);
        end
        idle();
        checks++;
        if (ferr_cnt !== 0) begin
            failures++;
            $display("FAIL hunt_no_ferr got=%0d exp=0", ferr_cnt);
        end
    endtask

    task automatic test_resync();
        ferr_cnt = 0;
        bus.out_ready = 1'b1;
        beat(1'b1, 1'b1, 8'h10);
        beat(1'b1, 1'b0, 8'h20);
        checks++;
        if (bus.frame_err !== 1'b0) begin
            failures++;
            $display("FAIL resync_ferr_early got=%b exp=0", bus.frame_err);
        end
        beat(1'b1, 1'b1, 8'h50);
        checks++;
        if (bus.frame_err !== 1'b1) begin
            failures++;
            $display("FAIL resync_ferr_pulse got=%b exp=1", bus.frame_err);
        end
        beat(1'b1, 1'b0, 8'h60);
        checks++;
        if (bus.frame_err !== 1'b0) begin
            failures++;
            $display("FAIL resync_ferr_clear got=%b exp=0", bus.frame_err);
        end
        beat(1'b1, 1'b0, 8'h70);
        beat(1'b1, 1'b0, 8'h80);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h80706050) begin
            failures++;
            $display("FAIL resync_frame got valid=%b data=%h exp valid=1 data=80706050", bus.out_valid, bus.out_data);
        end
        idle();
        checks++;
        if (ferr_cnt !== 1) begin
            failures++;
            $display("FAIL resync_ferr_count got=%0d exp=1", ferr_cnt);
        end
    endtask

    task automatic test_overrun();
        ovr_cnt = 0;
        bus.out_ready = 1'b0;
        beat(1'b1, 1'b1, 8'hA1);
        beat(1'b1, 1'b0, 8'hA2);
        beat(1'b1, 1'b0, 8'hA3);
        beat(1'b1, 1'b0, 8'hA4);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA4A3A2A1) begin
            failures++;
            $display("FAIL ovr_first got valid=%b data=%h exp valid=1 data=A4A3A2A1", bus.out_valid, bus.out_data);
        end
        beat(1'b1, 1'b1, 8'hB1);
        beat(1'b1, 1'b0, 8'hB2);
        beat(1'b1, 1'b0, 8'hB3);
        beat(1'b1, 1'b0, 8'hB4);
        checks++;
        if (bus.overrun !== 1'b1 || bus.out_data !== 32'hA4A3A2A1) begin
            failures++;
            $display("FAIL ovr_pulse got ovr=%b data=%h exp ovr=1 data=A4A3A2A1", bus.overrun, bus.out_data);
        end
        idle();
        checks++;
        if (bus.overrun !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 32'hA4A3A2A1) begin
            failures++;
            $display("FAIL ovr_hold got ovr=%b valid=%b data=%h exp ovr=0 valid=1 data=A4A3A2A1", bus.overrun, bus.out_valid, bus.out_data);
        end
        bus.out_ready = 1'b1;
        idle();
        checks++;
        if (bus.out_valid !== 1'b0 || ovr_cnt !== 1) begin
            failures++;
            $display("FAIL ovr_release got valid=%b count=%0d exp valid=0 count=1", bus.out_valid, ovr_cnt);
        end
    endtask

    task automatic test_back_to_back();
        ovr_cnt = 0;
        bus.out_ready = 1'b0;
        beat(1'b1, 1'b1, 8'hC1); idle();
        beat(1'b1, 1'b0, 8'hC2); idle();
        beat(1'b1, 1'b0, 8'hC3); idle();
        beat(1'b1, 1'b0, 8'hC4);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hC4C3C2C1) begin
            failures++;
            $display("FAIL b2b_first got valid=%b data=%h exp valid=1 data=C4C3C2C1", bus.out_valid, bus.out_data);
        end
        beat(1'b1, 1'b1, 8'hD1); idle();
        beat(1'b1, 1'b0, 8'hD2); idle();
        beat(1'b1, 1'b0, 8'hD3); idle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hC4C3C2C1) begin
            failures++;
            $display("FAIL b2b_hold got valid=%b data=%h exp valid=1 data=C4C3C2C1", bus.out_valid, bus.out_data);
        end
        bus.out_ready = 1'b1;
        beat(1'b1, 1'b0, 8'hD4);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hD4D3D2D1) begin
            failures++;
            $display("FAIL b2b_reload got valid=%b data=%h exp valid=1 data=D4D3D2D1", bus.out_valid, bus.out_data);
        end
        idle();
        checks++;
        if (bus.out_valid !== 1'b0 || ovr_cnt !== 0) begin
            failures++;
            $display("FAIL b2b_drain got valid=%b ovr_count=%0d exp valid=0 ovr_count=0", bus.out_valid, ovr_cnt);
        end
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        beat(1'b1, 1'b1, 8'hF1);
        beat(1'b1, 1'b0, 8'hF2);
        beat(1'b1, 1'b0, 8'hF3);
        beat(1'b1, 1'b0, 8'hF4);
        beat(1'b1, 1'b1, 8'hE1);
        beat(1'b1, 1'b0, 8'hE2);
        beat(1'b1, 1'b0, 8'hE3);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin
            failures++;
            $display("FAIL areset_clear got valid=%b data=%h exp valid=0 data=00000000", bus.out_valid, bus.out_data);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin
            failures++;
            $display("FAIL areset_hold got valid=%b data=%h exp valid=0 data=00000000", bus.out_valid, bus.out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        beat(1'b1, 1'b0, 8'h99);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL areset_hunt got valid=%b exp=0", bus.out_valid);
        end
        beat(1'b1, 1'b1, 8'h05);
        beat(1'b1, 1'b0, 8'h06);
        beat(1'b1, 1'b0, 8'h07);
        beat(1'b1, 1'b0, 8'h08);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h08070605) begin
            failures++;
            $display("FAIL areset_frame got valid=%b data=%h exp valid=1 data=08070605", bus.out_valid, bus.out_data);
        end
        idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ferr_cnt = 0;
        ovr_cnt  = 0;
        test_reset();
        test_nominal();
        test_hunt_discard();
        test_resync();
        test_overrun();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
